// File: rtl/ar_router.sv
// AXI4 read-address router: one master, five slaves, one outstanding read.
// Optional decode-error responder enabled by defining AR_DECERR_EN.
module ar_router #(
    parameter logic [31:0] SLV0_BASE   = 32'h0000_0000,
    parameter logic [31:0] SLV1_BASE   = 32'h1000_0000,
    parameter logic [31:0] SLV2_BASE   = 32'h2000_0000,
    parameter logic [31:0] SLV3_BASE   = 32'h3000_0000,
    parameter logic [31:0] SLV4_BASE   = 32'h4000_0000,
    parameter int unsigned REGION_BITS = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m_araddr,
    input  logic [7:0]  m_arlen,
    input  logic [2:0]  m_arsize,
    input  logic [1:0]  m_arburst,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    output logic        s_arvalid0,
    output logic        s_arvalid1,
    output logic        s_arvalid2,
    output logic        s_arvalid3,
    output logic        s_arvalid4,
    input  logic        s_arready0,
    input  logic        s_arready1,
    input  logic        s_arready2,
    input  logic        s_arready3,
    input  logic        s_arready4,
    input  logic        m_rvalid,
    input  logic        m_rready,
    input  logic        m_rlast,
`ifdef AR_DECERR_EN
    output logic        err_rvalid,
    output logic        err_rlast,
    output logic [1:0]  err_rresp,
    output logic [31:0] err_rdata,
`endif
    output logic [2:0]  ar_sel_q,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StData,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic        m_arready_q, m_arready_d;
    logic [2:0]  ar_sel_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [1:0]  arburst_q, arburst_d;

    logic [2:0]  dec_sel;
    logic        dec_hit;
    logic [4:0]  s_arready_vec;
    logic [4:0]  s_arvalid_vec;
    logic        sel_ready;
    logic        r_last_hs;

`ifdef AR_DECERR_EN
    logic [7:0]  beat_q, beat_d;
`endif

    // Region match on the bits above the region size only.
    function automatic logic region_hit(input logic [31:0] addr, input logic [31:0] base);
        return ((addr ^ base) >> REGION_BITS) == 32'd0;
    endfunction

    always_comb begin
        dec_hit = 1'b1;
        dec_sel = 3'd0;
        if (region_hit(m_araddr, SLV0_BASE)) begin
            dec_sel = 3'd0;
        end else if (region_hit(m_araddr, SLV1_BASE)) begin
            dec_sel = 3'd1;
        end else if (region_hit(m_araddr, SLV2_BASE)) begin
            dec_sel = 3'd2;
        end else if (region_hit(m_araddr, SLV3_BASE)) begin
            dec_sel = 3'd3;
        end else if (region_hit(m_araddr, SLV4_BASE)) begin
            dec_sel = 3'd4;
        end else begin
            dec_hit = 1'b0;
`ifdef AR_DECERR_EN
            dec_sel = 3'd5;
`else
            dec_sel = 3'd0;
`endif
        end
    end

    assign s_arready_vec = {s_arready4, s_arready3, s_arready2, s_arready1, s_arready0};

    // Only the selected slave's ready counts; indices above 4 never match.
    always_comb begin
        sel_ready     = 1'b0;
        s_arvalid_vec = 5'b0;
        case (ar_sel_q)
            3'd0: sel_ready = s_arready_vec[0];
            3'd1: sel_ready = s_arready_vec[1];
            3'd2: sel_ready = s_arready_vec[2];
            3'd3: sel_ready = s_arready_vec[3];
            3'd4: sel_ready = s_arready_vec[4];
            default: sel_ready = 1'b0;
        endcase
        if (state_q == StSend) begin
            case (ar_sel_q)
                3'd0: s_arvalid_vec = 5'b00001;
                3'd1: s_arvalid_vec = 5'b00010;
                3'd2: s_arvalid_vec = 5'b00100;
                3'd3: s_arvalid_vec = 5'b01000;
                3'd4: s_arvalid_vec = 5'b10000;
                default: s_arvalid_vec = 5'b0;
            endcase
        end
    end

    assign r_last_hs = m_rvalid & m_rready & m_rlast;

    always_comb begin
        state_d     = state_q;
        m_arready_d = m_arready_q;
        ar_sel_d    = ar_sel_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        arburst_d   = arburst_q;
`ifdef AR_DECERR_EN
        beat_d      = beat_q;
`endif
        case (state_q)
            StIdle: begin
                m_arready_d = 1'b1;
                if (m_arvalid && m_arready_q) begin
                    araddr_d    = m_araddr;
                    arlen_d     = m_arlen;
                    arsize_d    = m_arsize;
                    arburst_d   = m_arburst;
                    ar_sel_d    = dec_sel;
                    m_arready_d = 1'b0;
                    state_d     = StSend;
`ifdef AR_DECERR_EN
                    if (!dec_hit) begin
                        state_d = StErr;
                        beat_d  = 8'd0;
                    end
`endif
                end
            end
            StSend: begin
                if (sel_ready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (r_last_hs) begin
                    state_d     = StIdle;
                    m_arready_d = 1'b1;
                end
            end
`ifdef AR_DECERR_EN
            StErr: begin
                if (m_rready) begin
                    if (beat_q == arlen_q) begin
                        state_d     = StIdle;
                        m_arready_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
`endif
            default: begin
                state_d     = StIdle;
                m_arready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            m_arready_q <= 1'b0;
            ar_sel_q    <= 3'd0;
            araddr_q    <= 32'd0;
            arlen_q     <= 8'd0;
            arsize_q    <= 3'd0;
            arburst_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            m_arready_q <= m_arready_d;
            ar_sel_q    <= ar_sel_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            arburst_q   <= arburst_d;
        end
    end

`ifdef AR_DECERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= 8'd0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign err_rvalid = (state_q == StErr);
    assign err_rlast  = (state_q == StErr) && (beat_q == arlen_q);
    assign err_rresp  = 2'b11;
    assign err_rdata  = 32'd0;
`else
    logic unused_dec_hit;
    assign unused_dec_hit = dec_hit;
`endif

    assign m_arready  = m_arready_q;
    assign s_araddr   = araddr_q;
    assign s_arlen    = arlen_q;
    assign s_arsize   = arsize_q;
    assign s_arburst  = arburst_q;
    assign s_arvalid0 = s_arvalid_vec[0];
    assign s_arvalid1 = s_arvalid_vec[1];
    assign s_arvalid2 = s_arvalid_vec[2];
    assign s_arvalid3 = s_arvalid_vec[3];
    assign s_arvalid4 = s_arvalid_vec[4];
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ar_router.sv
// Directed self-checking bench for ar_router; covers the decode-error path when
// AR_DECERR_EN is defined.
module tb_ar_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid0, s_arvalid1, s_arvalid2, s_arvalid3, s_arvalid4;
    logic        s_arready0, s_arready1, s_arready2, s_arready3, s_arready4;
    logic        m_rvalid, m_rready, m_rlast;
    logic [2:0]  ar_sel_q;
    logic        busy;
`ifdef AR_DECERR_EN
    logic        err_rvalid, err_rlast;
    logic [1:0]  err_rresp;
    logic [31:0] err_rdata;
`endif

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ar_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arsize   (m_arsize),
        .m_arburst  (m_arburst),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .s_araddr   (s_araddr),
        .s_arlen    (s_arlen),
        .s_arsize   (s_arsize),
        .s_arburst  (s_arburst),
        .s_arvalid0 (s_arvalid0),
        .s_arvalid1 (s_arvalid1),
        .s_arvalid2 (s_arvalid2),
        .s_arvalid3 (s_arvalid3),
        .s_arvalid4 (s_arvalid4),
        .s_arready0 (s_arready0),
        .s_arready1 (s_arready1),
        .s_arready2 (s_arready2),
        .s_arready3 (s_arready3),
        .s_arready4 (s_arready4),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rlast    (m_rlast),
`ifdef AR_DECERR_EN
        .err_rvalid (err_rvalid),
        .err_rlast  (err_rlast),
        .err_rresp  (err_rresp),
        .err_rdata  (err_rdata),
`endif
        .ar_sel_q   (ar_sel_q),
        .busy       (busy)
    );

    function automatic logic [4:0] arv();
        return {s_arvalid4, s_arvalid3, s_arvalid2, s_arvalid1, s_arvalid0};
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [4:0] r);
        {s_arready4, s_arready3, s_arready2, s_arready1, s_arready0} = r;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [7:0] len);
        m_araddr  = addr;
        m_arlen   = len;
        m_arsize  = 3'd2;
        m_arburst = 2'b01;
        m_arvalid = 1'b1;
        step();
        m_arvalid = 1'b0;
    endtask

    task automatic last_beat();
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rlast  = 1'b1;
        step();
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = 1'b0;
        set_ready(5'b0);
        m_rvalid = 1'b0; m_rready = 1'b0; m_rlast = 1'b0;
        #3;
        tests_run++;
        if ({m_arready, busy, ar_sel_q, arv()} !== 10'd0) begin
            fails++;
            $display("FAIL reset_ctrl: arready=%b busy=%b sel=%0d arvalid=%b, want all 0",
                     m_arready, busy, ar_sel_q, arv());
        end
        tests_run++;
        if ({s_araddr, s_arlen, s_arsize, s_arburst} !== 45'd0) begin
            fails++;
            $display("FAIL reset_payload: addr=%h len=%0d size=%0d burst=%0d, want 0",
                     s_araddr, s_arlen, s_arsize, s_arburst);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (m_arready !== 1'b0) begin
            fails++;
            $display("FAIL arready_before_edge: got %b want 0", m_arready);
        end
        step();
        tests_run++;
        if (m_arready !== 1'b1) begin
            fails++;
            $display("FAIL arready_after_release: got %b want 1", m_arready);
        end
    endtask

    task automatic test_basic();
        issue(32'h2000_0040, 8'd3);
        tests_run++;
        if (arv() !== 5'b00100 || ar_sel_q !== 3'd2 || m_arready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_send: arvalid=%b sel=%0d arready=%b busy=%b, want 00100 2 0 1",
                     arv(), ar_sel_q, m_arready, busy);
        end
        tests_run++;
        if (s_arlen !== 8'd3 || s_araddr !== 32'h2000_0040 || s_arburst !== 2'b01) begin
            fails++;
            $display("FAIL basic_payload: addr=%h len=%0d burst=%0d, want 20000040 3 1",
                     s_araddr, s_arlen, s_arburst);
        end
        set_ready(5'b00100);
        step();
        set_ready(5'b0);
        tests_run++;
        if (arv() !== 5'b0 || busy !== 1'b1 || m_arready !== 1'b0) begin
            fails++;
            $display("FAIL basic_data: arvalid=%b busy=%b arready=%b, want 0 1 0",
                     arv(), busy, m_arready);
        end
        // Non-last beats must not end the burst.
        m_rvalid = 1'b1; m_rready = 1'b1; m_rlast = 1'b0;
        step(); step(); step();
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_nonlast: busy=%b want 1", busy);
        end
        last_beat();
        tests_run++;
        if (busy !== 1'b0 || m_arready !== 1'b1 || ar_sel_q !== 3'd2) begin
            fails++;
            $display("FAIL basic_done: busy=%b arready=%b sel=%0d, want 0 1 2",
                     busy, m_arready, ar_sel_q);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        issue(32'h4000_0000, 8'd0);
        m_araddr = 32'hDEAD_BEEF;
        set_ready(5'b01111);
        for (int i = 0; i < 5; i++) begin
            if (arv() !== 5'b10000 || s_araddr !== 32'h4000_0000 || s_arlen !== 8'd0) bad++;
            step();
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_hold: %0d bad cycles, want 0 (arvalid=%b addr=%h)",
                     bad, arv(), s_araddr);
        end
        tests_run++;
        if (arv() !== 5'b10000) begin
            fails++;
            $display("FAIL backpressure_still: arvalid=%b want 10000", arv());
        end
        set_ready(5'b10000);
        step();
        set_ready(5'b0);
        tests_run++;
        if (arv() !== 5'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: arvalid=%b busy=%b want 0 1", arv(), busy);
        end
        last_beat();
    endtask

    task automatic test_blocked_in_data();
        int bad = 0;
        issue(32'h3000_0010, 8'd1);
        // Last-beat handshake while still in SEND must be ignored.
        m_rvalid = 1'b1; m_rready = 1'b1; m_rlast = 1'b1;
        step();
        m_rvalid = 1'b0; m_rready = 1'b0; m_rlast = 1'b0;
        tests_run++;
        if (arv() !== 5'b01000) begin
            fails++;
            $display("FAIL send_ignores_rlast: arvalid=%b want 01000", arv());
        end
        set_ready(5'b01000);
        step();
        set_ready(5'b0);
        m_araddr = 32'h1000_0000;
        m_arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (m_arready !== 1'b0 || ar_sel_q !== 3'd3) bad++;
            step();
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL data_blocks_ar: %0d bad cycles, want 0", bad);
        end
        m_rvalid = 1'b1; m_rready = 1'b1; m_rlast = 1'b1;
        step();
        m_rvalid = 1'b0; m_rready = 1'b0; m_rlast = 1'b0;
        tests_run++;
        if (m_arready !== 1'b1 || ar_sel_q !== 3'd3 || busy !== 1'b0) begin
            fails++;
            $display("FAIL data_exit: arready=%b sel=%0d busy=%b, want 1 3 0",
                     m_arready, ar_sel_q, busy);
        end
        step();
        m_arvalid = 1'b0;
        tests_run++;
        if (ar_sel_q !== 3'd1 || arv() !== 5'b00010) begin
            fails++;
            $display("FAIL pending_accept: sel=%0d arvalid=%b, want 1 00010", ar_sel_q, arv());
        end
        set_ready(5'b00010);
        step();
        set_ready(5'b0);
        last_beat();
    endtask

    task automatic test_reset_mid_data();
        issue(32'h1000_0200, 8'd7);
        set_ready(5'b00010);
        step();
        set_ready(5'b0);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({m_arready, busy, ar_sel_q, arv()} !== 10'd0 || s_araddr !== 32'd0 || s_arlen !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid: arready=%b busy=%b sel=%0d arvalid=%b addr=%h len=%0d, want 0",
                     m_arready, busy, ar_sel_q, arv(), s_araddr, s_arlen);
        end
        step();
        rst_n = 1'b1;
        step();
        issue(32'h3000_0000, 8'd0);
        tests_run++;
        if (ar_sel_q !== 3'd3 || arv() !== 5'b01000) begin
            fails++;
            $display("FAIL after_reset_accept: sel=%0d arvalid=%b, want 3 01000", ar_sel_q, arv());
        end
        set_ready(5'b01000);
        step();
        set_ready(5'b0);
        last_beat();
    endtask

    task automatic test_unmapped();
        issue(32'h9000_0000, 8'd2);
`ifdef AR_DECERR_EN
        m_rready = 1'b1;
        tests_run++;
        if (ar_sel_q !== 3'd5 || arv() !== 5'b0 || err_rvalid !== 1'b1 || err_rlast !== 1'b0
            || err_rresp !== 2'b11 || err_rdata !== 32'd0) begin
            fails++;
            $display("FAIL decerr_beat0: sel=%0d arvalid=%b rvalid=%b rlast=%b rresp=%b",
                     ar_sel_q, arv(), err_rvalid, err_rlast, err_rresp);
        end
        step();
        tests_run++;
        if (err_rvalid !== 1'b1 || err_rlast !== 1'b0) begin
            fails++;
            $display("FAIL decerr_beat1: rvalid=%b rlast=%b, want 1 0", err_rvalid, err_rlast);
        end
        step();
        tests_run++;
        if (err_rvalid !== 1'b1 || err_rlast !== 1'b1 || arv() !== 5'b0) begin
            fails++;
            $display("FAIL decerr_beat2: rvalid=%b rlast=%b arvalid=%b, want 1 1 0",
                     err_rvalid, err_rlast, arv());
        end
        step();
        m_rready = 1'b0;
        tests_run++;
        if (err_rvalid !== 1'b0 || busy !== 1'b0 || m_arready !== 1'b1) begin
            fails++;
            $display("FAIL decerr_done: rvalid=%b busy=%b arready=%b, want 0 0 1",
                     err_rvalid, busy, m_arready);
        end
`else
        tests_run++;
        if (ar_sel_q !== 3'd0 || arv() !== 5'b00001 || s_araddr !== 32'h9000_0000) begin
            fails++;
            $display("FAIL unmapped_default: sel=%0d arvalid=%b addr=%h, want 0 00001 90000000",
                     ar_sel_q, arv(), s_araddr);
        end
        set_ready(5'b00001);
        step();
        set_ready(5'b0);
        last_beat();
        tests_run++;
        if (busy !== 1'b0 || m_arready !== 1'b1) begin
            fails++;
            $display("FAIL unmapped_done: busy=%b arready=%b, want 0 1", busy, m_arready);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_blocked_in_data();
        test_reset_mid_data();
        test_unmapped();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/ar_router.md
Name: ar_router

Overview:
- Read-address-channel router for the single-master, five-slave AXI4 read path.
- Accepts one AR request from the master, decodes the address to a slave index, and forwards the AR beat to that slave.
- Holds the selected index on ar_sel_q until the read burst's last R beat completes; the R-channel mux consumes ar_sel_q.
- Allows one outstanding read transaction.

Parameters:
- SLV0_BASE, 32'h0000_0000, slave 0 region base
- SLV1_BASE, 32'h1000_0000, slave 1 region base
- SLV2_BASE, 32'h2000_0000, slave 2 region base
- SLV3_BASE, 32'h3000_0000, slave 3 region base
- SLV4_BASE, 32'h4000_0000, slave 4 region base
- REGION_BITS, 28, log2 region size; a slave matches when addr[31:REGION_BITS] == base[31:REGION_BITS]

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m_araddr  in  32  master read address
- m_arlen  in  8  burst length minus 1
- m_arsize  in  3  beat size
- m_arburst  in  2  burst type
- m_arvalid  in  1  master AR valid
- m_arready  out  1  AR accept, registered
- s_araddr  out  32  registered address, broadcast to all slaves
- s_arlen  out  8  registered arlen, broadcast
- s_arsize  out  3  registered arsize, broadcast
- s_arburst  out  2  registered arburst, broadcast
- s_arvalid0..s_arvalid4  out  1 each  per-slave AR valid
- s_arready0..s_arready4  in  1 each  per-slave AR ready
- m_rvalid, m_rready, m_rlast  in  1 each  master-side R handshake taps, used to detect burst end
- ar_sel_q  out  3  selected slave index, to the R-channel mux
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - m_arready = 0, all s_arvalidN = 0.
  - ar_sel_q = 3'b000, s_ar* payload = 0, busy = 0.
- m_arready rises on the first clk edge after reset release.
- State machine:
  - IDLE: m_arready = 1. When m_arvalid & m_arready:
    - latch payload into s_ar*;
    - decode, load ar_sel_q;
    - m_arready <= 0;
    - go to SEND.
  - SEND: s_arvalid[ar_sel_q] = 1; all other s_arvalidN = 0; payload held stable. When s_arready[ar_sel_q] is high on a clk edge, drop s_arvalid and go to DATA.
    - AR-to-slave latency: s_arvalid is asserted the cycle after master acceptance.
  - DATA: no s_arvalid asserted. When m_rvalid & m_rready & m_rlast, go to IDLE and set m_arready <= 1.
    - The next acceptance can occur no earlier than 1 cycle after the last R beat.
- Decode:
  - Priority is slave 0 highest down to slave 4.
  - An unmapped address selects index 0 (without the optional feature).
- ar_sel_q is stable from SEND entry until DATA exits; it is not cleared on return to IDLE.
- A last-beat handshake arriving during SEND is ignored; the slave cannot return data before AR acceptance.
- m_rvalid is ignored in IDLE.
- s_arready on a non-selected slave is ignored.
- Reset mid-burst: all state is dropped immediately and the router returns to IDLE; pending slave responses are lost.

Optional Feature:
- Macro: AR_DECERR_EN.
- When defined:
  - An unmapped address sets ar_sel_q = 3'b101 and enters state ERR; no s_arvalidN is asserted.
  - Extra ports: err_rvalid (out, 1), err_rlast (out, 1), err_rresp (out, 2) = 2'b11, err_rdata (out, 32) = 0.
  - ERR drives err_rvalid = 1 for arlen+1 beats, counted with an 8-bit beat counter that advances on err_rvalid & m_rready.
  - err_rlast is high on beat index arlen.
  - After the final beat, go to IDLE.
  - Top-level muxes err_* onto the master R channel when ar_sel_q == 5.
- When not defined: no ERR state and no err_* ports; unmapped addresses route to slave 0.

Test Plan:
- Reset, then m_araddr = 32'h2000_0040, arlen = 3, valid → m_arready 1 the cycle after reset release; s_arvalid2 the cycle after acceptance; ar_sel_q = 2; s_arlen = 3.
- Slave 4 holds s_arready4 low for 5 cycles, addr = 32'h4000_0000 → s_arvalid4 held 5+ cycles with payload stable; other s_arvalidN stay 0.
- During DATA, assert m_arvalid with 32'h1000_0000 → m_arready stays 0; accepted only the cycle after the m_rlast handshake; ar_sel_q unchanged until then.
- Assert rst_n low mid-DATA → all outputs go to their reset values immediately; a new AR is accepted after release.
- Unmapped address 32'h9000_0000 without the macro → ar_sel_q = 0, s_arvalid0 asserted.
- Unmapped address 32'h9000_0000, arlen = 2, with AR_DECERR_EN → ar_sel_q = 5; 3 err beats with rresp = 2'b11; err_rlast on the 3rd beat; no s_arvalidN asserted.
